// File: rtl/ber_align_checker_if.sv
// Sample/control bundle between the PRBS loopback source and the BER checker.
// Latency: none, wires only.
// Backpressure: none; samples are qualified by i_valid and i_enable only.
interface ber_align_checker_if #(
    parameter int MAX_DELAY = 1024,
    parameter int CNT_W     = 64
);
    localparam int OFF_W = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;

    logic             i_enable;
    logic             i_valid;
    logic             i_prbs;
    logic             i_rx;
    logic             i_clear;
    logic             o_locked;
    logic [OFF_W-1:0] o_offset;
    logic [CNT_W-1:0] o_bit_count;
    logic [CNT_W-1:0] o_err_count;
    logic             o_search_wrap;
    logic             o_lol;

    // Stimulus side: drives samples and controls, observes status.
    modport master (
        output i_enable, i_valid, i_prbs, i_rx, i_clear,
        input  o_locked, o_offset, o_bit_count, o_err_count, o_search_wrap, o_lol
    );

    // Checker side.
    modport slave (
        input  i_enable, i_valid, i_prbs, i_rx, i_clear,
        output o_locked, o_offset, o_bit_count, o_err_count, o_search_wrap, o_lol
    );
endinterface

// File: rtl/ber_align_checker.sv
// BER checker: searches reference delay for alignment, locks, counts bits/errors, detects loss of lock.
// Latency: status and counters update one cycle after the deciding sample.
// Backpressure: none; i_enable low freezes all state, i_valid low skips the sample.
module ber_align_checker #(
    parameter int MAX_DELAY = 1024,
    parameter int WINDOW    = 511,
    parameter int LOCK_THR  = 0,
    parameter int LOL_THR   = 64,
    parameter int CNT_W     = 64
) (
    input  logic               clock,
    input  logic               i_reset,
    ber_align_checker_if.slave bus
);
    localparam int OFF_W  = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
    localparam int WCNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int WERR_W = $clog2(WINDOW + 1);

    localparam logic [OFF_W-1:0]  OFF_LAST = OFF_W'(MAX_DELAY - 1);
    localparam logic [WCNT_W-1:0] WCNT_END = WCNT_W'(WINDOW - 1);

    typedef enum logic {
        S_SEARCH = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [MAX_DELAY-1:0] line_q, line_d;
    logic [OFF_W-1:0]     off_q, off_d;
    logic [WCNT_W-1:0]    wcnt_q, wcnt_d;
    logic [WERR_W-1:0]    werr_q, werr_d;
    logic [CNT_W-1:0]     bits_q, bits_d;
    logic [CNT_W-1:0]     errs_q, errs_d;
    logic                 wrap_q, wrap_d;
    logic                 lol_q, lol_d;

    logic                 ref_bit;
    logic                 err_bit;
    logic                 win_close;
    logic [WERR_W:0]      total;

    // Reference tap from the pre-shift line; offset 0 is the live PRBS bit.
    always_comb begin
        ref_bit   = (off_q == '0) ? bus.i_prbs : line_q[off_q - OFF_W'(1)];
        err_bit   = bus.i_rx ^ ref_bit;
        win_close = (wcnt_q == WCNT_END);
        total     = {1'b0, werr_q} + (WERR_W + 1)'(err_bit);
    end

    // Next-state: delay line, window bookkeeping, search/lock decisions, accumulators.
    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        off_d   = off_q;
        wcnt_d  = wcnt_q;
        werr_d  = werr_q;
        bits_d  = bits_q;
        errs_d  = errs_q;
        wrap_d  = 1'b0;
        lol_d   = 1'b0;
        if (bus.i_enable) begin
            // Clear beats accumulation of a coincident sample.
            if (bus.i_clear) begin
                bits_d = '0;
                errs_d = '0;
            end else if (bus.i_valid && (state_q == S_LOCKED)) begin
                bits_d = (&bits_q) ? bits_q : bits_q + CNT_W'(1);
                if (err_bit && !(&errs_q)) begin
                    errs_d = errs_q + CNT_W'(1);
                end
            end
            if (bus.i_valid) begin
                line_d = {line_q[MAX_DELAY-2:0], bus.i_prbs};
                if (win_close) begin
                    wcnt_d = '0;
                    werr_d = '0;
                    case (state_q)
                        S_SEARCH: begin
                            if (int'(total) <= LOCK_THR) begin
                                state_d = S_LOCKED;
                            end else if (off_q == OFF_LAST) begin
                                off_d  = '0;
                                wrap_d = 1'b1;
                            end else begin
                                off_d = off_q + OFF_W'(1);
                            end
                        end
                        S_LOCKED: begin
                            if (int'(total) > LOL_THR) begin
                                state_d = S_SEARCH;
                                off_d   = '0;
                                lol_d   = 1'b1;
                            end
                        end
                        default: state_d = S_SEARCH;
                    endcase
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                    werr_d = werr_q + WERR_W'(err_bit);
                end
            end
        end
    end

    // State register; reset wins over enable and everything else.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            state_q <= S_SEARCH;
            line_q  <= '0;
            off_q   <= '0;
            wcnt_q  <= '0;
            werr_q  <= '0;
            bits_q  <= '0;
            errs_q  <= '0;
            wrap_q  <= 1'b0;
            lol_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            off_q   <= off_d;
            wcnt_q  <= wcnt_d;
            werr_q  <= werr_d;
            bits_q  <= bits_d;
            errs_q  <= errs_d;
            wrap_q  <= wrap_d;
            lol_q   <= lol_d;
        end
    end

    assign bus.o_locked      = (state_q == S_LOCKED);
    assign bus.o_offset      = off_q;
    assign bus.o_bit_count   = bits_q;
    assign bus.o_err_count   = errs_q;
    assign bus.o_search_wrap = wrap_q;
    assign bus.o_lol         = lol_q;
endmodule

// File: tb/tb_ber_align_checker.sv
// Bench for ber_align_checker: two instances (long search / short search, narrow counters) on a shared PRBS9 stream.
// Latency: checks outputs on the falling edge after each rising edge.
// Backpressure: n/a; valid/enable patterns are driven directly.
module tb_ber_align_checker;
    localparam int A_MD = 1024, A_W = 64, A_LT = 0, A_LOL = 10, A_CW = 16;
    localparam int B_MD = 16,   B_W = 32, B_LT = 0, B_LOL = 10, B_CW = 4;
    localparam longint A_CMAX = (64'd1 << A_CW) - 1;
    localparam longint B_CMAX = (64'd1 << B_CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ber_align_checker_if #(.MAX_DELAY(A_MD), .CNT_W(A_CW)) ifa();
    ber_align_checker_if #(.MAX_DELAY(B_MD), .CNT_W(B_CW)) ifb();

    ber_align_checker #(.MAX_DELAY(A_MD), .WINDOW(A_W), .LOCK_THR(A_LT), .LOL_THR(A_LOL), .CNT_W(A_CW))
        dut_a (.clock(clk), .i_reset(rst), .bus(ifa));
    ber_align_checker #(.MAX_DELAY(B_MD), .WINDOW(B_W), .LOCK_THR(B_LT), .LOL_THR(B_LOL), .CNT_W(B_CW))
        dut_b (.clock(clk), .i_reset(rst), .bus(ifb));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit     locked;
        int     off;
        int     wcnt;
        int     werr;
        longint bits;
        longint errs;
        bit     wrap;
        bit     lol;
    } ms_t;

    ms_t ma, mb;
    bit  hq[$];     // past counted PRBS bits, newest first

    function automatic bit mref(input int d, input bit pr);
        if (d == 0) return pr;
        if (d - 1 < hq.size()) return hq[d-1];
        return 1'b0;
    endfunction

    function automatic ms_t mstep(input ms_t s, input int maxd, input int win, input int lthr,
                                  input int lolthr, input longint cmax, input bit r, input bit en,
                                  input bit v, input bit refb, input bit rx, input bit clr);
        ms_t n;
        int  e, tot;
        n = s;
        n.wrap = 1'b0;
        n.lol  = 1'b0;
        if (r) begin
            n.locked = 0; n.off = 0; n.wcnt = 0; n.werr = 0; n.bits = 0; n.errs = 0;
            return n;
        end
        if (!en) return n;
        e = (rx != refb) ? 1 : 0;
        if (clr) begin
            n.bits = 0;
            n.errs = 0;
        end else if (v && s.locked) begin
            n.bits = (s.bits + 1 > cmax) ? cmax : s.bits + 1;
            n.errs = (s.errs + e > cmax) ? cmax : s.errs + e;
        end
        if (v) begin
            if (s.wcnt == win - 1) begin
                tot = s.werr + e;
                n.wcnt = 0;
                n.werr = 0;
                if (!s.locked) begin
                    if (tot <= lthr) n.locked = 1;
                    else begin
                        n.off = (s.off + 1) % maxd;
                        n.wrap = (s.off == maxd - 1);
                    end
                end else if (tot > lolthr) begin
                    n.locked = 0;
                    n.off = 0;
                    n.lol = 1;
                end
            end else begin
                n.wcnt = s.wcnt + 1;
                n.werr = s.werr + e;
            end
        end
        return n;
    endfunction

    // Model advance on the same edge the DUT samples its inputs.
    always @(posedge clk) begin
        bit pr, ra, rb;
        pr = ifa.i_prbs;
        ra = mref(ma.off, pr);
        rb = mref(mb.off, pr);
        ma = mstep(ma, A_MD, A_W, A_LT, A_LOL, A_CMAX, rst, ifa.i_enable, ifa.i_valid, ra, ifa.i_rx, ifa.i_clear);
        mb = mstep(mb, B_MD, B_W, B_LT, B_LOL, B_CMAX, rst, ifb.i_enable, ifb.i_valid, rb, ifb.i_rx, ifb.i_clear);
        if (rst) hq.delete();
        else if (ifa.i_enable && ifa.i_valid) begin
            hq.push_front(pr);
            if (hq.size() > 1024) void'(hq.pop_back());
        end
    end

    task automatic cmp(input string nm, input bit lk, input int off, input longint bc, input longint ec,
                       input bit wr, input bit lo, input ms_t m);
        checks++;
        if (lk !== m.locked || off !== m.off || bc !== m.bits || ec !== m.errs || wr !== m.wrap || lo !== m.lol) begin
            errors++;
            $display("FAIL %s t=%0t got lk=%0d off=%0d bits=%0d errs=%0d wrap=%0d lol=%0d want lk=%0d off=%0d bits=%0d errs=%0d wrap=%0d lol=%0d",
                     nm, $time, lk, off, bc, ec, wr, lo, m.locked, m.off, m.bits, m.errs, m.wrap, m.lol);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        cmp("dut_a", ifa.o_locked, int'(ifa.o_offset), longint'(ifa.o_bit_count), longint'(ifa.o_err_count),
            ifa.o_search_wrap, ifa.o_lol, ma);
        cmp("dut_b", ifb.o_locked, int'(ifb.o_offset), longint'(ifb.o_bit_count), longint'(ifb.o_err_count),
            ifb.o_search_wrap, ifb.o_lol, mb);
    end

    // ---------------- stimulus ----------------
    int         nsamp = 0;
    bit         gen [8192];
    logic [8:0] lfsr = 9'h1FF;
    bit         inv_a = 0, inv_b = 0, mode_b = 0, clr_b = 0;

    function automatic bit dly(input int d);
        if (nsamp >= d && nsamp - d < 8192) return gen[nsamp-d];
        return 1'b0;
    endfunction

    task automatic tick(input bit en, input bit v);
        bit pr;
        pr = lfsr[8];
        if (nsamp < 8192) gen[nsamp] = pr;
        ifa.i_enable = en;  ifb.i_enable = en;
        ifa.i_valid  = v;   ifb.i_valid  = v;
        ifa.i_prbs   = pr;  ifb.i_prbs   = pr;
        ifa.i_rx     = dly(37) ^ inv_a;
        ifb.i_rx     = mode_b ? (dly(5) ^ inv_b) : 1'b0;
        ifa.i_clear  = 1'b0;
        ifb.i_clear  = clr_b;
        @(negedge clk);
        if (rst) begin
            nsamp = 0;
            lfsr  = 9'h1FF;
        end else if (en && v) begin
            nsamp++;
            lfsr = {lfsr[7:0], lfsr[8] ^ lfsr[4]};
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int  wraps, last_wrap, lock_n, inv_start, lol_n;
        bit  b_lock_seen, lol_seen;
        wraps = 0; last_wrap = 0; b_lock_seen = 0; lol_seen = 0;

        rst = 1'b1;
        repeat (2) tick(1, 1);
        rst = 1'b0;
        chk("reset_locked", int'(ifa.o_locked), 0);
        chk("reset_offset", int'(ifa.o_offset), 0);
        chk("reset_bits", int'(ifa.o_bit_count), 0);

        // Search for the 37-sample alignment; B sees a constant-zero stream.
        for (int i = 0; i < 3000 && !ifa.o_locked; i++) begin
            tick(1, 1);
            if (ifb.o_search_wrap) begin
                wraps++;
                chk("t4_wrap_period", nsamp - last_wrap, 512);
                last_wrap = nsamp;
            end
            if (ifb.o_locked) b_lock_seen = 1;
        end
        chk("t1_lock_samples", nsamp, 2432);
        chk("t1_offset", int'(ifa.o_offset), 37);
        chk("t1_err_zero", int'(ifa.o_err_count), 0);
        chk("t1_bits_zero", int'(ifa.o_bit_count), 0);
        chk("t4_wrap_count", wraps, 4);
        chk("t4_never_locked", int'(b_lock_seen), 0);
        lock_n = nsamp;

        // Three isolated bit errors on A; B now sees PRBS delayed by 5.
        mode_b = 1;
        for (int i = 0; i < 420; i++) begin
            inv_a = (i == 50 || i == 120 || i == 200);
            tick(1, 1);
        end
        inv_a = 0;
        chk("t2_err3", int'(ifa.o_err_count), 3);
        chk("t2_bits", int'(ifa.o_bit_count), nsamp - lock_n);
        chk("t2_locked", int'(ifa.o_locked), 1);
        chk("b_locked", int'(ifb.o_locked), 1);
        chk("b_offset", int'(ifb.o_offset), 5);
        chk("t5_bits_sat", int'(ifb.o_bit_count), 15);

        // Clear coinciding with a locked sample: that sample is dropped.
        clr_b = 1;
        tick(1, 1);
        clr_b = 0;
        chk("t5_clear_bits", int'(ifb.o_bit_count), 0);
        chk("t5_clear_errs", int'(ifb.o_err_count), 0);
        tick(1, 1);
        chk("t5_bits_after_clear", int'(ifb.o_bit_count), 1);

        // Inverted stream on B: error count pins at all-ones.
        inv_b = 1;
        repeat (20) tick(1, 1);
        chk("t5_err_sat", int'(ifb.o_err_count), 15);
        chk("t5_still_locked", int'(ifb.o_locked), 1);
        repeat (10) tick(1, 1);
        chk("t5_lol_retains", int'(ifb.o_err_count), 15);
        inv_b = 0;

        // Whole-window inversion on A forces loss of lock, then relock at 37.
        inv_start = nsamp;
        inv_a = 1;
        for (int i = 0; i < 200 && !lol_seen; i++) begin
            tick(1, 1);
            if (ifa.o_lol) lol_seen = 1;
        end
        inv_a = 0;
        chk("t3_lol_seen", int'(lol_seen), 1);
        chk("t3_unlocked", int'(ifa.o_locked), 0);
        chk("t3_offset0", int'(ifa.o_offset), 0);
        chk("t3_bits_kept", int'(ifa.o_bit_count), nsamp - lock_n);
        chk("t3_errs_kept", int'(ifa.o_err_count), 3 + nsamp - inv_start);
        lol_n = nsamp;
        tick(1, 1);
        chk("t3_lol_one_cycle", int'(ifa.o_lol), 0);
        for (int i = 0; i < 3000 && !ifa.o_locked; i++) tick(1, 1);
        chk("t3_relock_samples", nsamp - lol_n, 2432);
        chk("t3_relock_offset", int'(ifa.o_offset), 37);

        // Sparse valid and enable-low bursts: same alignment in counted samples.
        rst = 1'b1;
        tick(1, 1);
        rst = 1'b0;
        mode_b = 0;
        for (int k = 0; k < 12000 && !ifa.o_locked; k++) tick((k % 50) < 45, (k % 3) == 0);
        chk("t6_lock_samples", nsamp, 2432);
        chk("t6_offset", int'(ifa.o_offset), 37);
        for (int k = 0; k < 40; k++) tick(1, (k % 3) == 0);
        chk("t6_counting", int'(ifa.o_bit_count > 0), 1);

        // Reset with enable low, mid-lock.
        rst = 1'b1;
        tick(0, 0);
        rst = 1'b0;
        chk("t6_rst_locked", int'(ifa.o_locked), 0);
        chk("t6_rst_offset", int'(ifa.o_offset), 0);
        chk("t6_rst_bits", int'(ifa.o_bit_count), 0);
        chk("t6_rst_errs", int'(ifa.o_err_count), 0);
        tick(0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
